// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: configurable word length, parity and stop bits,
// 16x (OVERSAMPLE) mid-bit sampling on RX with glitch rejection and error flags.
module uart_core_param #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_100m,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int TICK_RAW = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int TDW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OSW      = $clog2(STOP_BITS * OVERSAMPLE);
  localparam int IDXW     = $clog2(DATA_BITS);

  localparam logic [TDW-1:0]  TICK_LAST = TDW'(TICK_DIV - 1);
  localparam logic [OSW-1:0]  OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0]  OS_HALF   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0]  STOP_LAST = OSW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DATA_BITS - 1);
  localparam logic            PAR_ODD   = (PARITY == 1);
  localparam logic            HAS_PAR   = (PARITY != 0);

  // ---------------------------------------------------------------- tick gen
  logic [TDW-1:0] tick_cnt;
  logic           tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------------------------------------------------------- TX
  // Handshake: a word transfers on any rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so tx_valid is ignored for the whole frame.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  tx_state_t             tx_state, tx_state_n;
  logic [OSW-1:0]        tx_os, tx_os_n;
  logic [IDXW-1:0]       tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0]  tx_shift, tx_shift_n;
  logic                  tx_par, tx_par_n;
  logic                  tx_q, tx_q_n;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_os    <= tx_os_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_q     <= tx_q_n;
    end
  end

  // A line level is driven on the tick that starts its bit; tx_os then counts
  // the remaining ticks, so every bit spans exactly OVERSAMPLE ticks.
  always_comb begin
    tx_state_n = tx_state;
    tx_os_n    = tx_os;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_q_n     = tx_q;
    case (tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_n = TX_START;
          tx_shift_n = tx_data;
          tx_par_n   = (^tx_data) ^ PAR_ODD;
          tx_os_n    = '0;
          tx_idx_n   = '0;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_q) begin
            tx_q_n  = 1'b0;
            tx_os_n = '0;
          end else if (tx_os == OS_LAST) begin
            tx_state_n = TX_DATA;
            tx_q_n     = tx_shift[0];
            tx_os_n    = '0;
            tx_idx_n   = '0;
          end else begin
            tx_os_n = tx_os + 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_os == OS_LAST) begin
            tx_os_n = '0;
            if (tx_idx == IDX_LAST) begin
              if (HAS_PAR) begin
                tx_state_n = TX_PARITY;
                tx_q_n     = tx_par;
              end else begin
                tx_state_n = TX_STOP;
                tx_q_n     = 1'b1;
              end
            end else begin
              tx_idx_n   = tx_idx + 1'b1;
              tx_shift_n = tx_shift >> 1;
              tx_q_n     = tx_shift[1];
            end
          end else begin
            tx_os_n = tx_os + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          if (tx_os == OS_LAST) begin
            tx_state_n = TX_STOP;
            tx_q_n     = 1'b1;
            tx_os_n    = '0;
          end else begin
            tx_os_n = tx_os + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_os == STOP_LAST) begin
            tx_state_n = TX_IDLE;
            tx_os_n    = '0;
          end else begin
            tx_os_n = tx_os + 1'b1;
          end
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_q_n     = 1'b1;
      end
    endcase
  end

  assign tx_ready = (tx_state == TX_IDLE);
  assign tx       = tx_q;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  logic                 rx_s1, rx_s2;
  rx_state_t            rx_state, rx_state_n;
  logic [OSW-1:0]       rx_os, rx_os_n;
  logic [IDXW-1:0]      rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_par_bit, rx_par_bit_n;
  logic                 rx_deliver;
  logic                 rx_frame_bad;
  logic                 rx_par_bad;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_os      <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_os      <= rx_os_n;
      rx_idx     <= rx_idx_n;
      rx_shift   <= rx_shift_n;
      rx_par_bit <= rx_par_bit_n;
    end
  end

  // START re-checks the line half a bit after the falling edge; every later
  // sample lands a whole bit further on, i.e. mid-bit.
  always_comb begin
    rx_state_n   = rx_state;
    rx_os_n      = rx_os;
    rx_idx_n     = rx_idx;
    rx_shift_n   = rx_shift;
    rx_par_bit_n = rx_par_bit;
    rx_deliver   = 1'b0;
    rx_frame_bad = 1'b0;
    rx_par_bad   = 1'b0;
    if (tick) begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_state_n = RX_START;
            rx_os_n    = '0;
          end
        end
        RX_START: begin
          if (rx_os == OS_HALF) begin
            rx_os_n  = '0;
            rx_idx_n = '0;
            if (rx_s2) rx_state_n = RX_IDLE;
            else       rx_state_n = RX_DATA;
          end else begin
            rx_os_n = rx_os + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_os == OS_LAST) begin
            rx_os_n    = '0;
            rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == IDX_LAST) rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
            else                    rx_idx_n   = rx_idx + 1'b1;
          end else begin
            rx_os_n = rx_os + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_os == OS_LAST) begin
            rx_os_n      = '0;
            rx_par_bit_n = rx_s2;
            rx_state_n   = RX_STOP;
          end else begin
            rx_os_n = rx_os + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_os == OS_LAST) begin
            rx_os_n      = '0;
            rx_deliver   = 1'b1;
            rx_frame_bad = !rx_s2;
            rx_par_bad   = HAS_PAR && ((^rx_shift) ^ rx_par_bit ^ PAR_ODD);
            rx_state_n   = rx_s2 ? RX_IDLE : RX_BREAK;
          end else begin
            rx_os_n = rx_os + 1'b1;
          end
        end
        RX_BREAK: begin
          // a line held low must return high before another frame can start
          if (rx_s2) rx_state_n = RX_IDLE;
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  // Output holding register: a pending word is never overwritten unless the
  // consumer acknowledges it in the same cycle.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (rx_deliver) begin
      if (!rx_valid || rx_ack) begin
        rx_data       <= rx_shift;
        rx_valid      <= 1'b1;
        rx_frame_err  <= rx_frame_bad;
        rx_parity_err <= rx_par_bad;
        rx_overrun    <= 1'b0;
      end else begin
        rx_overrun <= 1'b1;
      end
    end else if (rx_ack && rx_valid) begin
      rx_valid      <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: an 8N1 instance (optionally looped back)
// and a 7E2 instance, both at 16 clocks per bit.
module tb_uart_core_param;

  logic       clk_100m = 1'b0;
  logic       rst_n;

  logic [7:0] tx_data_a;
  logic       tx_valid_a, tx_ready_a, tx_a;
  logic       rx_a, rx_drv_a, loop_a;
  logic [7:0] rx_data_a;
  logic       rx_valid_a, rx_ack_a, fe_a, pe_a, ov_a;

  logic [6:0] tx_data_b;
  logic       tx_valid_b, tx_ready_b, tx_b;
  logic       rx_drv_b;
  logic [6:0] rx_data_b;
  logic       rx_valid_b, rx_ack_b, fe_b, pe_b, ov_b;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  assign rx_a = loop_a ? tx_a : rx_drv_a;

  uart_core_param #(
    .CLK_HZ(100000000), .BAUD(6250000), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .OVERSAMPLE(16)
  ) u_a (
    .clk_100m(clk_100m), .rst_n(rst_n),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx(tx_a),
    .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ack(rx_ack_a),
    .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ov_a)
  );

  uart_core_param #(
    .CLK_HZ(100000000), .BAUD(6250000), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(2), .OVERSAMPLE(16)
  ) u_b (
    .clk_100m(clk_100m), .rst_n(rst_n),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx(tx_b),
    .rx(rx_drv_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ack(rx_ack_b),
    .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ov_b)
  );

  // clock / watchdog
  always #5 clk_100m = ~clk_100m;

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? tx_ready_a : tx_ready_b;
  endfunction

  // start bit at [0], data LSB first, stop at [9]
  function automatic logic [15:0] f8(input logic [7:0] d, input logic stp);
    return {6'b0, stp, d, 1'b0};
  endfunction

  // driver tasks (all called and returning at a negedge)
  task automatic send_tx(input int sel, input logic [7:0] d);
    if (sel == 0) begin tx_data_a = d;      tx_valid_a = 1'b1; end
    else          begin tx_data_b = d[6:0]; tx_valid_b = 1'b1; end
    @(negedge clk_100m);
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    check("tx_ready_drop", ready_of(sel), 1'b0);
  endtask

  task automatic capture_tx(input int sel, input int nbits,
                            output logic [15:0] bits, output int rdy);
    logic found;
    int   cnt;
    int   idx;
    bits  = '0;
    rdy   = -1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (tx_of(sel) == 1'b0) found = 1'b1;
      else @(negedge clk_100m);
    end
    check("tx_start_seen", found, 1'b1);
    if (found) begin
      cnt = 0;
      idx = 0;
      while (cnt < 400 && rdy < 0) begin
        @(negedge clk_100m);
        cnt++;
        if (idx < nbits && cnt == 8 + 16 * idx) begin
          bits[idx] = tx_of(sel);
          idx++;
        end
        if (ready_of(sel)) rdy = cnt;
      end
    end
  endtask

  task automatic drive_frame(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_drv_a = bits[i];
      else          rx_drv_b = bits[i];
      repeat (16) @(negedge clk_100m);
    end
  endtask

  task automatic ack_a();
    rx_ack_a = 1'b1;
    @(negedge clk_100m);
    rx_ack_a = 1'b0;
  endtask

  initial begin
    logic [15:0] bits;
    int          rdy;
    logic        found;

    rst_n = 1'b0;
    tx_data_a = '0; tx_valid_a = 1'b0; rx_drv_a = 1'b1; loop_a = 1'b0; rx_ack_a = 1'b0;
    tx_data_b = '0; tx_valid_b = 1'b0; rx_drv_b = 1'b1; rx_ack_b = 1'b0;
    repeat (3) @(negedge clk_100m);
    check("rst_tx", tx_a, 1'b1);
    check("rst_tx_ready", tx_ready_a, 1'b1);
    check("rst_rx_valid", rx_valid_a, 1'b0);
    check("rst_rx_data", rx_data_a, 8'h00);
    check("rst_flags", {fe_a, pe_a, ov_a}, 3'b000);
    check("rst_b_idle", {tx_b, tx_ready_b, rx_valid_b}, 3'b110);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_100m);

    // 8N1 loopback of 0xA5
    loop_a = 1'b1;
    exp_q.push_back(8'hA5);
    send_tx(0, 8'hA5);
    capture_tx(0, 10, bits, rdy);
    check("a5_tx_bits", bits, f8(8'hA5, 1'b1));
    check("a5_ready_clocks", rdy, 160);
    check("a5_rx_valid", rx_valid_a, 1'b1);
    check("a5_rx_data", rx_data_a, exp_q.pop_front());
    check("a5_flags", {fe_a, pe_a, ov_a}, 3'b000);
    loop_a = 1'b0;
    ack_a();
    check("a5_ack_clears", rx_valid_a, 1'b0);

    // 7E2: transmit 0x55 (even parity 0, two stop bits)
    send_tx(1, 8'h55);
    capture_tx(1, 11, bits, rdy);
    check("b55_tx_bits", bits, {5'b0, 2'b11, 1'b0, 7'h55, 1'b0});
    check("b55_ready_clocks", rdy, 176);
    // same frame with the parity bit flipped
    drive_frame(1, {5'b0, 2'b11, 1'b1, 7'h55, 1'b0}, 11);
    repeat (10) @(negedge clk_100m);
    check("b55_rx_valid", rx_valid_b, 1'b1);
    check("b55_rx_data", rx_data_b, 7'h55);
    check("b55_parity_err", pe_b, 1'b1);
    check("b55_frame_err", fe_b, 1'b0);

    // framing error followed by a held-low line
    exp_q.push_back(8'h3C);
    drive_frame(0, f8(8'h3C, 1'b0), 10);
    repeat (640) @(negedge clk_100m);
    check("3c_rx_valid", rx_valid_a, 1'b1);
    check("3c_rx_data", rx_data_a, exp_q.pop_front());
    check("3c_flags", {fe_a, pe_a, ov_a}, 3'b100);
    rx_drv_a = 1'b1;
    repeat (20) @(negedge clk_100m);
    ack_a();
    check("3c_ack_clears", {rx_valid_a, fe_a}, 2'b00);
    exp_q.push_back(8'h81);
    drive_frame(0, f8(8'h81, 1'b1), 10);
    repeat (10) @(negedge clk_100m);
    check("81_rx_data", rx_data_a, exp_q.pop_front());
    check("81_valid_flags", {rx_valid_a, fe_a, pe_a, ov_a}, 4'b1000);
    ack_a();

    // overrun: 0x11 then 0x22 with no acknowledge
    exp_q.push_back(8'h11);
    drive_frame(0, f8(8'h11, 1'b1), 10);
    drive_frame(0, f8(8'h22, 1'b1), 10);
    repeat (10) @(negedge clk_100m);
    check("ovr_rx_data", rx_data_a, exp_q.pop_front());
    check("ovr_flags", {rx_valid_a, ov_a}, 2'b11);
    ack_a();
    check("ovr_ack_clears", {rx_valid_a, ov_a}, 2'b00);
    exp_q.push_back(8'h33);
    drive_frame(0, f8(8'h33, 1'b1), 10);
    repeat (10) @(negedge clk_100m);
    check("33_rx_data", rx_data_a, exp_q.pop_front());
    check("33_valid_flags", {rx_valid_a, fe_a, pe_a, ov_a}, 4'b1000);
    ack_a();

    // 4-clock glitch is rejected
    rx_drv_a = 1'b0;
    repeat (4) @(negedge clk_100m);
    rx_drv_a = 1'b1;
    repeat (30) @(negedge clk_100m);
    check("glitch_no_valid", rx_valid_a, 1'b0);
    check("glitch_rx_idle", 32'(u_a.rx_state), 0);

    // acknowledge coincident with delivery of 0x44 while 0x5A is pending
    drive_frame(0, f8(8'h5A, 1'b1), 10);
    repeat (10) @(negedge clk_100m);
    check("5a_pending", rx_valid_a, 1'b1);
    exp_q.push_back(8'h44);
    found = 1'b0;
    fork
      drive_frame(0, f8(8'h44, 1'b1), 10);
      begin
        for (int i = 0; i < 300 && !found; i++) begin
          @(negedge clk_100m);
          if (u_a.rx_deliver) found = 1'b1;
        end
        if (found) ack_a();
      end
    join
    check("44_deliver_seen", found, 1'b1);
    repeat (10) @(negedge clk_100m);
    check("44_rx_data", rx_data_a, exp_q.pop_front());
    check("44_valid_ovr", {rx_valid_a, ov_a}, 2'b10);
    ack_a();

    // reset during the third data bit of 0xF0
    send_tx(0, 8'hF0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (tx_a == 1'b0) found = 1'b1;
      else @(negedge clk_100m);
    end
    check("f0_start_seen", found, 1'b1);
    repeat (56) @(negedge clk_100m);
    check("f0_bit2_low", tx_a, 1'b0);
    rst_n = 1'b0;
    #1;
    check("f0_async_tx", tx_a, 1'b1);
    check("f0_async_ready", tx_ready_a, 1'b1);
    @(negedge clk_100m);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100m);
    send_tx(0, 8'h0F);
    capture_tx(0, 10, bits, rdy);
    check("0f_tx_bits", bits, f8(8'h0F, 1'b1));
    check("0f_ready_clocks", rdy, 160);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
